pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/riscv_pkg.sv | 12 +
 rtl/hazard_detect.sv | 20 ++
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the pipeline control slice.
package riscv_pkg;

   localparam int unsigned PERF_CNT_W = 32;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
module hazard_detect (
   input  logic       i_ex_mem_read,
   input  logic [4:0] i_ex_rd_addr,
   input  logic [4:0] i_id_rs1_addr,
   input  logic [4:0] i_id_rs2_addr,
   input  logic       i_id_uses_rs1,
   input  logic       i_id_uses_rs2,
   output logic       o_load_use
);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit  = i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr);
   assign w_rs2_hit  = i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr);
   // x0 is never a real destination, so a load to it cannot create a hazard.
   assign o_load_use = i_ex_mem_read & (i_ex_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: priority mux, redirect/mem-wait FSM and
// saturating performance counters.
module pipeline_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_W = PERF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   input  logic              id_uses_rs1_i,
   input  logic              id_uses_rs2_i,
   input  logic              ex_mem_read_i,
   input  logic [4:0]        ex_rd_addr_i,
   input  logic              ex_redirect_i,
   input  logic              dmem_req_i,
   input  logic              dmem_ready_i,
   input  logic              cnt_clr_i,
   output logic              pc_stall_o,
   output logic              if_id_stall_o,
   output logic              if_id_flush_o,
   output logic              id_ex_stall_o,
   output logic              id_ex_flush_o,
   output logic              ex_mem_stall_o,
   output ctrl_state_t       state_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   ctrl_state_t      r_state;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_mem_wait;
   logic w_load_use;
   logic w_pc_stall;
   logic w_if_id_stall;
   logic w_if_id_flush;
   logic w_id_ex_stall;
   logic w_id_ex_flush;
   logic w_ex_mem_stall;

   assign w_mem_wait = dmem_req_i & ~dmem_ready_i;

   hazard_detect u_hazard_detect (
      .i_ex_mem_read (ex_mem_read_i),
      .i_ex_rd_addr  (ex_rd_addr_i),
      .i_id_rs1_addr (id_rs1_addr_i),
      .i_id_rs2_addr (id_rs2_addr_i),
      .i_id_uses_rs1 (id_uses_rs1_i),
      .i_id_uses_rs2 (id_uses_rs2_i),
      .o_load_use    (w_load_use)
   );

   always_comb begin
      w_pc_stall     = 1'b0;
      w_if_id_stall  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_stall  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_stall = 1'b0;
      if (w_mem_wait) begin
         w_pc_stall     = 1'b1;
         w_if_id_stall  = 1'b1;
         w_id_ex_stall  = 1'b1;
         w_ex_mem_stall = 1'b1;
      end else if (ex_redirect_i) begin
         w_if_id_flush  = 1'b1;
         w_id_ex_flush  = 1'b1;
      end else if (r_state == REDIRECT) begin
         // Squash the wrong-path fetch still in flight from the imem.
         w_if_id_flush  = 1'b1;
      end else if (w_load_use) begin
         w_pc_stall     = 1'b1;
         w_if_id_stall  = 1'b1;
         w_id_ex_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else if (w_mem_wait) begin
         r_state <= MEM_WAIT;
      end else if (ex_redirect_i) begin
         r_state <= REDIRECT;
      end else begin
         r_state <= RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (cnt_clr_i) begin
            r_stall_cnt <= '0;
         end else if (w_pc_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (cnt_clr_i) begin
            r_flush_cnt <= '0;
         end else if (w_id_ex_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign pc_stall_o     = w_pc_stall;
   assign if_id_stall_o  = w_if_id_stall;
   assign if_id_flush_o  = w_if_id_flush;
   assign id_ex_stall_o  = w_id_ex_stall;
   assign id_ex_flush_o  = w_id_ex_flush;
   assign ex_mem_stall_o = w_ex_mem_stall;
   assign state_o        = r_state;
   assign stall_cnt_o    = r_stall_cnt;
   assign flush_cnt_o    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a cycle-level reference model; a second
// narrow-counter instance exercises saturation.
module tb_pipeline_ctrl;
   import riscv_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
   logic       dmem_req, dmem_ready, cnt_clr;

   logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
   ctrl_state_t state;
   logic [31:0] stall_cnt, flush_cnt;

   logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush, s_ex_mem_stall;
   ctrl_state_t s_state;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
      .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .ex_mem_read_i(ex_mem_read), .ex_rd_addr_i(ex_rd_addr),
      .ex_redirect_i(ex_redirect), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
      .cnt_clr_i(cnt_clr),
      .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
      .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush), .ex_mem_stall_o(ex_mem_stall),
      .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   pipeline_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
      .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .ex_mem_read_i(ex_mem_read), .ex_rd_addr_i(ex_rd_addr),
      .ex_redirect_i(ex_redirect), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
      .cnt_clr_i(cnt_clr),
      .pc_stall_o(s_pc_stall), .if_id_stall_o(s_if_id_stall), .if_id_flush_o(s_if_id_flush),
      .id_ex_stall_o(s_id_ex_stall), .id_ex_flush_o(s_id_ex_flush), .ex_mem_stall_o(s_ex_mem_stall),
      .state_o(s_state), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
   );

   // Reference model: the state is fully determined by what happened last cycle.
   logic        m_prev_mw, m_prev_redir;
   logic [31:0] m_stall, m_flush;
   logic [3:0]  m_sstall, m_sflush;
   logic        m_mw, m_lu;
   logic [5:0]  m_ctrl;  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}
   ctrl_state_t m_state;

   assign m_mw = dmem_req && !dmem_ready;
   assign m_lu = ex_mem_read && (ex_rd_addr != 5'd0) &&
                 ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
   assign m_state = m_prev_mw ? MEM_WAIT : (m_prev_redir ? REDIRECT : RUN);

   always_comb begin
      m_ctrl = 6'b000000;
      if (m_mw)                     m_ctrl = 6'b110101;
      else if (ex_redirect)         m_ctrl = 6'b001010;
      else if (m_state == REDIRECT) m_ctrl = 6'b001000;
      else if (m_lu)                m_ctrl = 6'b110010;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_prev_mw <= 1'b0; m_prev_redir <= 1'b0;
         m_stall <= 32'd0; m_flush <= 32'd0; m_sstall <= 4'd0; m_sflush <= 4'd0;
      end else begin
         m_prev_mw    <= m_mw;
         m_prev_redir <= !m_mw && ex_redirect;
         if (cnt_clr) begin
            m_stall <= 32'd0; m_flush <= 32'd0; m_sstall <= 4'd0; m_sflush <= 4'd0;
         end else begin
            if (m_ctrl[5] && m_stall  != 32'hFFFF_FFFF) m_stall  <= m_stall + 32'd1;
            if (m_ctrl[1] && m_flush  != 32'hFFFF_FFFF) m_flush  <= m_flush + 32'd1;
            if (m_ctrl[5] && m_sstall != 4'hF)          m_sstall <= m_sstall + 4'd1;
            if (m_ctrl[1] && m_sflush != 4'hF)          m_sflush <= m_sflush + 4'd1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc_stall",     32'(pc_stall),     32'(m_ctrl[5]));
         chk("if_id_stall",  32'(if_id_stall),  32'(m_ctrl[4]));
         chk("if_id_flush",  32'(if_id_flush),  32'(m_ctrl[3]));
         chk("id_ex_stall",  32'(id_ex_stall),  32'(m_ctrl[2]));
         chk("id_ex_flush",  32'(id_ex_flush),  32'(m_ctrl[1]));
         chk("ex_mem_stall", 32'(ex_mem_stall), 32'(m_ctrl[0]));
         chk("state",        32'(state),        32'(m_state));
         chk("stall_cnt",    stall_cnt,         m_stall);
         chk("flush_cnt",    flush_cnt,         m_flush);
         chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(m_sstall));
         chk("sat_flush_cnt", 32'(s_flush_cnt), 32'(m_sflush));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
      dmem_req = 1'b0; dmem_ready = 1'b0; cnt_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #2;
      chk("reset_state", 32'(state), 32'(RUN));
      chk("reset_stall_cnt", stall_cnt, 32'd0);
      chk("reset_flush_cnt", flush_cnt, 32'd0);
      #10 rst_n = 1'b1;
      next_cycle();
      chk_en = 1'b1;

      // load-use on rs2
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
      #2;
      chk("lu_pc_stall", 32'(pc_stall), 32'd1);
      chk("lu_if_id_stall", 32'(if_id_stall), 32'd1);
      chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
      chk("lu_if_id_flush", 32'(if_id_flush), 32'd0);
      next_cycle();
      ex_mem_read = 1'b0;
      #2;
      chk("lu_bubble_pc_stall", 32'(pc_stall), 32'd0);
      chk("lu_stall_cnt", stall_cnt, 32'd1);
      chk("lu_flush_cnt", flush_cnt, 32'd1);
      next_cycle();

      // load to x0: no hazard
      ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
      id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
      #2;
      chk("x0_pc_stall", 32'(pc_stall), 32'd0);
      chk("x0_id_ex_flush", 32'(id_ex_flush), 32'd0);
      next_cycle();
      ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_rs2_addr = 5'd3; id_uses_rs2 = 1'b0;
      next_cycle();
      id_uses_rs1 = 1'b0;
      next_cycle();
      idle();
      next_cycle();

      // single redirect pulse, load-use during REDIRECT is ignored
      ex_redirect = 1'b1;
      #2;
      chk("rd_n_if_id_flush", 32'(if_id_flush), 32'd1);
      chk("rd_n_id_ex_flush", 32'(id_ex_flush), 32'd1);
      next_cycle();
      ex_redirect = 1'b0;
      ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
      #2;
      chk("rd_n1_state", 32'(state), 32'(REDIRECT));
      chk("rd_n1_if_id_flush", 32'(if_id_flush), 32'd1);
      chk("rd_n1_id_ex_flush", 32'(id_ex_flush), 32'd0);
      chk("rd_n1_pc_stall", 32'(pc_stall), 32'd0);
      next_cycle();
      idle();
      #2;
      chk("rd_n2_state", 32'(state), 32'(RUN));
      chk("rd_n2_if_id_flush", 32'(if_id_flush), 32'd0);
      next_cycle();

      // back-to-back redirects
      ex_redirect = 1'b1;
      next_cycle();
      #2;
      chk("b2b_state", 32'(state), 32'(REDIRECT));
      chk("b2b_id_ex_flush", 32'(id_ex_flush), 32'd1);
      next_cycle();
      ex_redirect = 1'b0;
      next_cycle();
      next_cycle();

      // mem wait with redirect held, then redirect acted on
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("mw_ex_mem_stall", 32'(ex_mem_stall), 32'd1);
         chk("mw_if_id_flush", 32'(if_id_flush), 32'd0);
         next_cycle();
      end
      dmem_ready = 1'b1;
      #2;
      chk("mw_end_state", 32'(state), 32'(MEM_WAIT));
      chk("mw_end_id_ex_flush", 32'(id_ex_flush), 32'd1);
      chk("mw_end_pc_stall", 32'(pc_stall), 32'd0);
      chk("mw_stall_cnt", stall_cnt, 32'd3);
      next_cycle();
      idle();
      #2;
      chk("mw_post_state", 32'(state), 32'(REDIRECT));
      next_cycle();
      next_cycle();

      // saturation on the 4-bit instance, then clear while still stalling
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (17) next_cycle();
      #2;
      chk("sat_stall_narrow", 32'(s_stall_cnt), 32'hF);
      chk("sat_stall_wide", stall_cnt, 32'd17);
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      #2;
      chk("clr_stall_cnt", stall_cnt, 32'd0);
      chk("clr_sat_stall", 32'(s_stall_cnt), 32'd0);
      next_cycle();
      dmem_req = 1'b0;
      ex_redirect = 1'b1;
      repeat (18) next_cycle();
      #2;
      chk("sat_flush_narrow", 32'(s_flush_cnt), 32'hF);
      chk("sat_flush_wide", flush_cnt, 32'd18);
      next_cycle();
      ex_redirect = 1'b0;
      next_cycle();
      next_cycle();

      // asynchronous reset during MEM_WAIT
      dmem_req = 1'b1; dmem_ready = 1'b0;
      next_cycle();
      dmem_req = 1'b0;
      #2;
      chk("pre_rst_state", 32'(state), 32'(MEM_WAIT));
      chk("pre_rst_stall_cnt", stall_cnt, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'(RUN));
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);
      chk("rst_ctrl", {26'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}, 32'd0);
      next_cycle();
      rst_n = 1'b1;
      repeat (3) next_cycle();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
